// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - pops bytes from the upstream FIFO and shifts each out as an 8N1 UART frame
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_deq,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEQ   = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tx_nx, deq_nx;
    logic                 baud_tc, last_bit, in_bit;

    assign baud_tc  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_idx == IW'(DATA_BITS - 1));
    assign in_bit   = (state == START) || (state == DATA) || (state == STOP);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tx_en && !fifo_empty) state_nx = DEQ;
            DEQ:     state_nx = LATCH;
            LATCH:   state_nx = START;
            START:   if (baud_tc) state_nx = DATA;
            DATA:    if (baud_tc && last_bit) state_nx = STOP;
            STOP:    if (baud_tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered line and pop request.
    always_comb begin
        tx_nx  = tx;
        deq_nx = 1'b0;
        case (state)
            IDLE: begin
                tx_nx  = 1'b1;
                deq_nx = tx_en && !fifo_empty;
            end
            LATCH:   tx_nx = 1'b0;
            START:   if (baud_tc) tx_nx = shift_reg[0];
            DATA:    if (baud_tc) tx_nx = last_bit ? 1'b1 : shift_reg[1];
            STOP:    tx_nx = 1'b1;
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx        <= 1'b1;
            fifo_deq  <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            tx       <= tx_nx;
            fifo_deq <= deq_nx;
            baud_cnt <= (in_bit && !baud_tc) ? baud_cnt + CW'(1) : '0;
            if (state == LATCH) begin
                shift_reg <= fifo_dout;
            end else if (state == DATA && baud_tc) begin
                shift_reg <= shift_reg >> 1;
            end
            if (state == START && baud_tc) begin
                bit_idx <= '0;
            end else if (state == DATA && baud_tc && !last_bit) begin
                bit_idx <= bit_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - self-checking bench for uart_tx_drain with a depth-4 FIFO model and a frame decoder
module tb_uart_tx_drain;
    localparam int C  = 4;
    localparam int CF = 868;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, tx_en;
    logic       fifo_empty, fifo_deq, tx, busy;
    logic [7:0] fifo_dout = 8'h00;
    logic       f_tx_en, f_empty, f_deq, f_tx, f_busy;
    logic [7:0] f_dout = 8'hC3;

    uart_tx_drain #(.CLKS_PER_BIT(C), .DATA_BITS(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_deq(fifo_deq), .tx(tx), .busy(busy)
    );

    uart_tx_drain #(.CLKS_PER_BIT(CF), .DATA_BITS(8)) u_full (
        .clk(clk), .reset_n(reset_n), .tx_en(f_tx_en), .fifo_empty(f_empty),
        .fifo_dout(f_dout), .fifo_deq(f_deq), .tx(f_tx), .busy(f_busy)
    );

    // Depth-4 FIFO: dout updates on the edge that samples deq.
    logic [7:0] mem [4];
    logic [1:0] wr_ptr = 2'd0, rd_ptr = 2'd0;
    int         count = 0;
    logic       enq = 1'b0;
    logic [7:0] enq_data = 8'h00;
    assign fifo_empty = (count == 0);

    always @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= enq_data;
            wr_ptr      <= wr_ptr + 2'd1;
        end
        if (fifo_deq && count != 0) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 2'd1;
        end
        count <= count + (enq ? 1 : 0) - ((fifo_deq && count != 0) ? 1 : 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int fall_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame decoder and scoreboard on the C=4 instance.
    logic       in_frame = 1'b0, prev_tx = 1'b1, cur = 1'b1, glitch = 1'b0;
    logic [9:0] frame_bits = '0;
    logic [7:0] exp_b;
    int pos = 0, last_fall = -1000, deq_cyc = 0;
    int frames_started = 0, frames_done = 0, deq_cnt = 0, underflow = 0, tx_low_cnt = 0, f_deq_cnt = 0;

    always @(negedge clk) begin
        if (f_deq) f_deq_cnt++;
        if (!reset_n) begin
            in_frame = 1'b0;
            prev_tx  = 1'b1;
        end else begin
            if (!in_frame && prev_tx && !tx) begin
                in_frame = 1'b1;
                pos      = 0;
                glitch   = 1'b0;
                last_fall = cyc;
                fall_q.push_back(cyc);
                frames_started++;
            end
            if (in_frame) begin
                if (pos % C == 0) cur = tx;
                else if (tx !== cur) glitch = 1'b1;
                if (pos % C == C - 1) frame_bits[pos / C] = cur;
                if (pos == 10 * C - 1) begin
                    check("bit_stable", glitch, 1'b0);
                    check("start_bit", frame_bits[0], 1'b0);
                    check("stop_bit", frame_bits[9], 1'b1);
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_frame", 0, 1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("sb_byte", frame_bits[8:1], exp_b);
                    end
                    in_frame = 1'b0;
                    frames_done++;
                end
                pos++;
            end
            prev_tx = tx;
            if (tx === 1'b0) tx_low_cnt++;
            if (fifo_deq) begin
                deq_cnt++;
                deq_cyc = cyc;
                if (fifo_empty) underflow++;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        enq      = 1'b1;
        enq_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        enq = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        int n = 0;
        while (frames_done < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", frames_done >= target, 1);
    endtask

    int c0, n0, d0, low0, fi, fc, k, lim;
    logic [7:0] f_byte;

    initial begin
        reset_n = 1'b0; tx_en = 1'b1; f_tx_en = 1'b1; f_empty = 1'b1;

        // Reset hold with a byte waiting and enable high.
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_deq", fifo_deq, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        check("rst_fifo_kept", fifo_empty, 1'b0);
        @(negedge clk) reset_n = 1'b1;

        // Single byte 0xA5.
        wait_frames(1, 200);
        check("a5_deq_to_fall", last_fall - deq_cyc, 2);
        @(negedge clk);
        check("a5_busy_low", busy, 1'b0);
        check("a5_fifo_empty", fifo_empty, 1'b1);
        repeat (20) @(negedge clk);
        check("a5_deq_count", deq_cnt, 1);

        // Back-to-back frames.
        fi = fall_q.size();
        n0 = frames_done;
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_frames(n0 + 3, 600);
        check("b2b_period_1", fall_q[fi + 1] - fall_q[fi], 10 * C + 3);
        check("b2b_period_2", fall_q[fi + 2] - fall_q[fi + 1], 10 * C + 3);
        repeat (20) @(negedge clk);
        check("b2b_deq_count", deq_cnt, 4);
        check("b2b_underflow", underflow, 0);

        // Empty FIFO, then disabled with a byte queued.
        low0 = tx_low_cnt; d0 = deq_cnt;
        repeat (100) @(negedge clk);
        check("empty_tx_idle", tx_low_cnt - low0, 0);
        check("empty_no_deq", deq_cnt - d0, 0);
        tx_en = 1'b0;
        push(8'h55);
        low0 = tx_low_cnt;
        repeat (100) @(negedge clk);
        check("dis_tx_idle", tx_low_cnt - low0, 0);
        check("dis_no_deq", deq_cnt - d0, 0);
        check("dis_fifo_held", fifo_empty, 1'b0);
        tx_en = 1'b1;
        c0 = cyc; n0 = frames_done;
        repeat (4) @(negedge clk);
        check("en_start_latency", last_fall - c0, 3);
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
        wait_frames(n0 + 1, 200);
        check("en_drop_deq_count", deq_cnt, 5);

        // Reset during data bit 3 of 0x81 with 0x42 behind it.
        tx_en = 1'b1;
        n0 = frames_started;
        push(8'h81); push(8'h42);
        lim = 0;
        while (frames_started == n0 && lim < 100) begin @(negedge clk); lim++; end
        check("mid_start_timeout", frames_started > n0, 1);
        lim = 0;
        while (cyc < last_fall + 4 * C + 2 && lim < 100) begin @(negedge clk); lim++; end
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_deq", fifo_deq, 1'b0);
        void'(exp_q.pop_front());
        n0 = frames_done;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_frames(n0 + 1, 200);
        repeat (5) @(negedge clk);
        check("mid_deq_count", deq_cnt, 7);
        check("sb_drained", exp_q.size(), 0);

        // Full-rate frame of 0xC3.
        @(negedge clk) f_empty = 1'b0;
        lim = 0;
        while (f_tx !== 1'b0 && lim < 20) begin
            @(negedge clk);
            if (f_deq) f_empty = 1'b1;
            lim++;
        end
        check("full_fall_timeout", f_tx, 1'b0);
        fc = cyc;
        lim = 0;
        while (f_tx !== 1'b1 && lim < 2 * CF) begin @(negedge clk); lim++; end
        check("full_start_len", cyc - fc, CF);
        for (k = 0; k < 8; k++) begin
            while (cyc - fc < CF * (k + 1) + CF / 2) @(negedge clk);
            f_byte[k] = f_tx;
        end
        lim = 0;
        while (f_busy !== 1'b0 && lim < 10 * CF) begin @(negedge clk); lim++; end
        check("full_frame_len", cyc - fc, 10 * CF);
        check("full_byte", f_byte, 8'hC3);
        check("full_deq_count", f_deq_cnt, 1);
        check("final_underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
